// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low row, samples synchronised
// columns per row, and debounces whole frames into one strobe per press.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2
  } state_t;

  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  logic [3:0]    r_col_meta;
  logic [3:0]    r_col_sync;
  logic [DW-1:0] r_div;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row;
  logic [15:0]   r_frame;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rcnt;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_down;

  logic          w_tick;
  logic          w_frame_done;
  logic [1:0]    w_idx_next;
  logic [15:0]   w_frame;
  logic [4:0]    w_count;
  logic [3:0]    w_pos;
  logic          w_single;
  logic          w_none;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_frame_done = w_tick && (r_row_idx == 2'd3);
  assign w_idx_next   = r_row_idx + 2'd1;
  // Frame including the row being sampled this cycle; a 0 column means closed.
  assign w_frame      = r_frame | ({12'h000, ~r_col_sync} << {r_row_idx, 2'b00});

  // Population count plus position of the (last) set bit in the frame.
  always_comb begin
    w_count = 5'd0;
    w_pos   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_frame[i]) begin
        w_count = w_count + 5'd1;
        w_pos   = 4'(i);
      end else begin
        w_count = w_count;
      end
    end
  end

  assign w_single = (w_count == 5'd1);
  assign w_none   = (w_count == 5'd0);

  // Two-flop column synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_meta <= 4'b1111;
      r_col_sync <= 4'b1111;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
    end
  end

  // Scan divider, row walker and frame accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div     <= '0;
      r_row_idx <= 2'd0;
      r_row     <= 4'b1110;
      r_frame   <= 16'h0000;
    end else if (w_tick) begin
      r_div     <= '0;
      r_row_idx <= w_idx_next;
      r_row     <= ~(4'b0001 << w_idx_next);
      r_frame   <= w_frame_done ? 16'h0000 : w_frame;
    end else begin
      r_div     <= r_div + DW'(1);
    end
  end

  // Debounce FSM with registered key outputs; advances once per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_pos;
              if (DEBOUNCE_SCANS == 1) begin
                r_key_code  <= key_map(w_pos);
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_cnt       <= '0;
                r_rcnt      <= '0;
                r_state     <= S_PRESSED;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (w_single && (w_pos == r_cand)) begin
              if ((r_cnt + CW'(1)) == DB_LAST) begin
                r_key_code  <= key_map(r_cand);
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_cnt       <= '0;
                r_rcnt      <= '0;
                r_state     <= S_PRESSED;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            // Any closure, even a multi-key one, keeps the press alive.
            if (w_none) begin
              if ((r_rcnt + CW'(1)) == DB_LAST) begin
                r_rcnt     <= '0;
                r_key_down <= 1'b0;
                r_state    <= S_IDLE;
              end else begin
                r_rcnt <= r_rcnt + CW'(1);
              end
            end else begin
              r_rcnt <= '0;
            end
          end
          default: begin
            r_cnt      <= '0;
            r_rcnt     <= '0;
            r_key_down <= 1'b0;
            r_state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle frames)
// and a behavioural 4x4 key matrix driving the column lines.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int double_cnt = 0;
  logic prev_valid = 1'b0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .reset(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
  end

  // Strobe monitor: counts pulses and flags any pulse wider than one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        strobe_cnt = strobe_cnt + 1;
        if (prev_valid) double_cnt = double_cnt + 1;
      end
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          strobes;
    logic [3:0]  code;
    logic        down;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    logic [3:0] exp_row;

    tbl[0]  = '{16'h0000, 2, 0, 4'h6, 1'b1};
    tbl[1]  = '{16'h0000, 1, 0, 4'h6, 1'b0};
    tbl[2]  = '{16'h1000, 3, 1, 4'hE, 1'b1};
    tbl[3]  = '{16'h0000, 3, 0, 4'hE, 1'b0};
    tbl[4]  = '{16'h0008, 1, 0, 4'hE, 1'b0};
    tbl[5]  = '{16'h0000, 1, 0, 4'hE, 1'b0};
    tbl[6]  = '{16'h0008, 2, 0, 4'hE, 1'b0};
    tbl[7]  = '{16'h0008, 1, 1, 4'hA, 1'b1};
    tbl[8]  = '{16'h0000, 3, 0, 4'hA, 1'b0};
    tbl[9]  = '{16'h0201, 5, 0, 4'hA, 1'b0};
    tbl[10] = '{16'h0001, 2, 0, 4'hA, 1'b0};
    tbl[11] = '{16'h0001, 1, 1, 4'h1, 1'b1};
    tbl[12] = '{16'h0000, 3, 0, 4'h1, 1'b0};
    tbl[13] = '{16'h0020, 3, 1, 4'h5, 1'b1};
    tbl[14] = '{16'h0040, 4, 0, 4'h5, 1'b1};
    tbl[15] = '{16'h0000, 2, 0, 4'h5, 1'b1};
    tbl[16] = '{16'h0060, 1, 0, 4'h5, 1'b1};
    tbl[17] = '{16'h0000, 2, 0, 4'h5, 1'b1};
    tbl[18] = '{16'h0000, 1, 0, 4'h5, 1'b0};

    // Idle scanning: row walk and quiet outputs.
    keys = 16'h0000;
    cycles(2);
    do_reset();
    chk("reset_row", {28'h0, row}, 32'hE);
    chk("reset_code", {28'h0, key_code}, 32'h0);
    chk("reset_down", {31'h0, key_down}, 32'h0);
    chk("reset_valid", {31'h0, key_valid}, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      cycles(4);
      exp_row = ~(4'b0001 << (i % 4));
      chk("row_walk", {28'h0, row}, {28'h0, exp_row});
    end
    chk("idle_strobes", strobe_cnt, 0);
    chk("idle_down", {31'h0, key_down}, 32'h0);

    // Key 6 held from reset release: strobe exactly after the 3rd frame.
    keys = 16'h0040;
    rst_n = 1'b0;
    cycles(3);
    s0 = strobe_cnt;
    rst_n = 1'b1;
    cycles(47);
    chk("k6_early", strobe_cnt - s0, 0);
    chk("k6_early_valid", {31'h0, key_valid}, 32'h0);
    cycles(1);
    chk("k6_valid", {31'h0, key_valid}, 32'h1);
    chk("k6_code", {28'h0, key_code}, 32'h6);
    chk("k6_down", {31'h0, key_down}, 32'h1);
    cycles(1);
    chk("k6_width", {31'h0, key_valid}, 32'h0);
    cycles(208 - 49);
    chk("k6_held_strobes", strobe_cnt - s0, 1);
    chk("k6_held_down", {31'h0, key_down}, 32'h1);

    // Frame-aligned table of key patterns.
    for (int i = 0; i < 19; i++) begin
      keys = tbl[i].keys;
      s0 = strobe_cnt;
      cycles(16 * tbl[i].frames);
      chk($sformatf("vec%0d_strobes", i), strobe_cnt - s0, tbl[i].strobes);
      chk($sformatf("vec%0d_code", i), {28'h0, key_code}, {28'h0, tbl[i].code});
      chk($sformatf("vec%0d_down", i), {31'h0, key_down}, {31'h0, tbl[i].down});
    end

    // Reset in mid-debounce with key 5 still held.
    keys = 16'h0020;
    do_reset();
    cycles(32);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row", {28'h0, row}, 32'hE);
    chk("mid_rst_code", {28'h0, key_code}, 32'h0);
    chk("mid_rst_valid", {31'h0, key_valid}, 32'h0);
    chk("mid_rst_down", {31'h0, key_down}, 32'h0);
    cycles(3);
    s0 = strobe_cnt;
    rst_n = 1'b1;
    cycles(47);
    chk("k5_early", strobe_cnt - s0, 0);
    cycles(1);
    chk("k5_valid", {31'h0, key_valid}, 32'h1);
    chk("k5_code", {28'h0, key_code}, 32'h5);
    cycles(16);
    chk("k5_strobes", strobe_cnt - s0, 1);

    chk("pulse_width", double_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and turns raw matrix activity into clean key events for `brain`.
- Sits directly upstream of `brain`, between the board keypad pins and the command logic.
- Drives one row low at a time, samples the columns, and debounces over whole scan frames.
- Emits one strobe per physical press with a 4-bit hex key code. Never auto-repeats.

Parameters:
- SCAN_DIV, 100000, clock cycles each row is driven (1 ms at 100 MHz); legal range is 2 or more.
- DEBOUNCE_SCANS, 4, consecutive identical full frames required to accept a press or a release; legal range is 1 or more.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- row  output  4  keypad row drive, one-hot active-low.
- col  input  4  keypad column sense, pulled up; 0 means key closed on the driven row.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle strobe when a new press is accepted.
- key_down  output  1  high from acceptance until the release is accepted.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - row=4'b1110, row index 0, divider 0;
  - key_code=0, key_valid=0, key_down=0;
  - FSM in IDLE; all counters and the frame accumulator cleared.
- Column synchroniser:
  - col passes through a 2-FF synchroniser (reset to 4'b1111) before any use.
- Divider and row sequencing:
  - The divider counts 0..SCAN_DIV-1. "tick" is the cycle it equals SCAN_DIV-1.
  - On tick, the synchronised col is sampled for the current row.
  - A pressed position is recorded as bit[4*r+c] of a 16-bit frame accumulator.
  - On the same tick the row index advances (3 wraps to 0) and row = ~(1<<idx).
- Frame evaluation:
  - A frame completes on the tick of row 3.
  - Frame result classes: NONE (0 bits set), SINGLE(k) (exactly 1 bit set), MULTI (2 or more bits set).
  - The accumulator clears for the next frame.
  - MULTI is treated identically to NONE in IDLE and DEBOUNCE. In PRESSED it counts as "not released".
- Key map, indexed [row][col] → code:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E(*), 0, F(#), D
- FSM (evaluated only on frame completion):
  - IDLE:
    - SINGLE(k) → cand=k, cnt=1, go to DEBOUNCE.
    - If DEBOUNCE_SCANS==1, go directly to PRESSED with acceptance instead.
    - Otherwise stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS, accept.
    - Any other result → IDLE, cnt=0.
  - PRESSED:
    - NONE → rcnt+1; when rcnt reaches DEBOUNCE_SCANS → IDLE, key_down=0, rcnt=0.
    - Any non-NONE result → rcnt=0, stay in PRESSED.
    - A different key pressed while held is not reported until a full release.
- Acceptance:
  - In the cycle after the frame-completion tick, key_valid=1 for exactly one cycle, key_code=cand, key_down=1.
  - key_code holds its value until the next acceptance.
- Latency:
  - First frame containing a stable press → strobe after DEBOUNCE_SCANS frames (4*SCAN_DIV cycles each), plus 1 cycle.
  - Add 2 cycles of synchroniser delay to any col edge.
- Mid-operation reset:
  - Reset asserted at any point aborts everything immediately.
  - No strobe is generated for a key that is still held at reset release until it passes full debounce again from IDLE.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 16 cycles):
1. Release reset, no keys → row cycles 1110, 1101, 1011, 0111 every 4 cycles, wrapping; key_valid never asserts; key_code=0, key_down=0.
2. Hold row1/col2 stable from reset release → exactly one key_valid pulse, 1 cycle wide, key_code=4'h6, key_down=1, on the cycle after the 3rd completed frame; no further pulses while held 10 frames.
3. Release the key from scenario 2 → key_down falls 1 cycle after the 3rd consecutive empty frame; no key_valid. Then press row3/col0 → key_code=4'hE with one strobe.
4. Row0/col3 chattering, open in frame 2 of 3 → no strobe; after the chatter stops and the key stays closed 3 frames → single strobe, key_code=4'hA.
5. Row0/col0 and row2/col1 pressed together for 5 frames → no strobe; releasing row2/col1 → strobe with key_code=4'h1 after 3 frames.
6. Hold row1/col1, assert reset after 2 frames (mid-DEBOUNCE), release reset with key still held → outputs at reset values during reset; strobe key_code=4'h5 occurs 3 full frames after reset release, not earlier.
